branch_redirect_unit: RTL and testbench
=======================================

# branch_redirect_unit

Fetch-side consumer of the branch decision in the MIPS pipeline. Owns the program counter, evaluates BEQ/BNE resolution from the ALU zero flag in EX, loads the branch or jump target, and drives a squash window over wrong-path instructions. It also keeps branch/taken statistics counters. It replaces the free-running PC register feeding instruction memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard stall; freezes PC, FSM, counters
- br_valid  in  1  conditional branch instruction present in EX
- br_beq  in  1  1 = BEQ, 0 = BNE
- z  in  1  ALU zero flag for the EX instruction
- br_pc4  in  32  PC+4 of the EX instruction
- br_imm  in  16  signed word offset of the EX instruction
- jump  in  1  J instruction present in EX
- jump_index  in  26  J target index
- pc  out  32  current fetch address
- flush  out  1  registered; EX instruction is wrong-path, consumer kills it
- redirect  out  1  registered pulse; PC was loaded from a target on the previous edge
- br_count  out  CNT_W  conditional branches resolved
- taken_count  out  CNT_W  conditional branches taken

## Operation
- taken = br_valid & (br_beq ? z : ~z); act = (taken | jump) & ~stall & (state == RUN).
- Branch target = br_pc4 + sign_extend(br_imm) << 2, modulo 2^32. Jump target = {br_pc4[31:28], jump_index, 2'b00}.
- jump has priority over taken if both are asserted.
- Next PC, no stall: act ? target : pc + 4. With stall: pc holds.
- FSM states: RUN, SLOT, SQUASH1, SQUASH2.
- RUN:
  - On act, go to SQUASH1, or to SLOT with delay slot enabled.
  - Otherwise stay in RUN.
- SLOT:
  - Holds for one non-stalled cycle; flush = 0, since the EX instruction is the delay slot.
  - Then go to SQUASH2.
- SQUASH1: flush = 1; then SQUASH2.
- SQUASH2: flush = 1; then RUN.
- In every state other than RUN, br_valid and jump are ignored: no redirect and no counting. The PC still advances by 4.
- Counters:
  - br_count increments on br_valid & ~stall & state == RUN.
  - taken_count increments on taken & ~stall & state == RUN.
  - Both wrap modulo 2^CNT_W.
- Stall in any state freezes state, pc, flush, and the counters. redirect is forced to 0 during stall.
- Reset, asynchronous and at any time including mid-squash:
  - pc = RESET_PC, state = RUN, flush = 0, redirect = 0, br_count = 0, taken_count = 0.
  - The first edge after deassertion fetches RESET_PC+4.

## Timing
- Resolution is combinational in the EX cycle. PC load happens on the same rising edge, so the target is fetched in the next cycle.
- redirect is high for exactly the one cycle after the loading edge.
- flush is high for 2 non-stalled cycles after the loading edge, covering the former ID and IF instructions as they reach EX. With delay slot enabled, flush is low for 1 cycle, then high for 1.
- A stalled branch in EX is re-evaluated each cycle and redirects on the first non-stalled edge.
- Back-to-back branches: a branch arriving in EX during SQUASH is wrong-path and is ignored.

## Configuration
- BRANCH_DELAY_SLOT_EN defined:
  - The SLOT state exists, and one wrong-path instruction is squashed.
  - The instruction after a branch or jump executes.
- BRANCH_DELAY_SLOT_EN undefined:
  - SLOT is never entered, and two instructions are squashed (SQUASH1 → SQUASH2).

## Test plan
- Reset: rst pulse mid-run with RESET_PC=0 → pc=0, flush=0, counters=0. Next three edges give pc=4, 8, 12.
- BEQ taken: br_valid=1, br_beq=1, z=1, br_pc4=0x100, br_imm=0xFFFE, no stall.
  - Next cycle: pc=0xF8, redirect=1, br_count=1, taken_count=1.
  - Without delay slot: flush=1 for 2 cycles.
  - With delay slot: flush 0 then 1.
- BNE not taken: br_beq=0, z=1, br_pc4=0x200 → pc continues +4, redirect=0, flush=0, br_count=1, taken_count=0.
- Jump: jump=1, jump_index=0x0000040, br_pc4=0x1000_0010 → pc=0x1000_0100. A br_valid asserted in the following squash cycle is ignored and the counters are unchanged.
- Stall: taken branch with stall=1 for 3 cycles → pc, state, and counters frozen, redirect=0. Redirect occurs on the first edge with stall=0.
- Counter wrap and reset mid-squash:
  - With CNT_W=4, 16 resolved branches → br_count=0.
  - rst asserted in SQUASH1 → flush drops immediately, pc=RESET_PC.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: resolves BEQ/BNE/J in EX, loads the target and squashes wrong-path instructions.
// Optional feature: define BRANCH_DELAY_SLOT_EN to let the instruction after a branch/jump execute.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_beq,
  input  logic             z,
  input  logic [31:0]      br_pc4,
  input  logic [15:0]      br_imm,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             redirect,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // state   | meaning
  // RUN     | normal fetch; branches and jumps in EX are honoured
  // SLOT    | EX holds the delay-slot instruction, which executes
  // SQUASH1 | EX holds the first wrong-path instruction
  // SQUASH2 | EX holds the last wrong-path instruction
  typedef enum logic [1:0] {RUN, SLOT, SQUASH1, SQUASH2} state_t;

  state_t      state, state_nxt;
  logic        in_run, taken, act, flush_nxt, redirect_q;
  logic [31:0] br_target, j_target, target, pc_nxt;

  assign in_run    = (state == RUN);
  assign taken     = br_valid & (br_beq ? z : ~z);
  assign act       = (taken | jump) & ~stall & in_run;
  assign br_target = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign j_target  = {br_pc4[31:28], jump_index, 2'b00};
  assign target    = jump ? j_target : br_target;
  assign pc_nxt    = act ? target : pc + 32'd4;
  assign redirect  = redirect_q & ~stall;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (act) begin
`ifdef BRANCH_DELAY_SLOT_EN
          state_nxt = SLOT;
`else
          state_nxt = SQUASH1;
`endif
        end
      end
      SLOT:    state_nxt = SQUASH2;
      SQUASH1: state_nxt = SQUASH2;
      SQUASH2: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    flush_nxt = (state_nxt == SQUASH1) || (state_nxt == SQUASH2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      flush       <= 1'b0;
      redirect_q  <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      // act is already gated by stall, so a stalled edge clears the pulse
      redirect_q <= act;
      if (!stall) begin
        state <= state_nxt;
        pc    <= pc_nxt;
        flush <= flush_nxt;
        if (in_run && br_valid) br_count    <= br_count + 1'b1;
        if (in_run && taken)    taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomised self-checking bench for branch_redirect_unit against a cycle-level reference model.
module tb_branch_redirect_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, br_valid = 1'b0, br_beq = 1'b0, z = 1'b0, jump = 1'b0;
  logic [31:0]   br_pc4 = '0;
  logic [15:0]   br_imm = '0;
  logic [25:0]   jump_index = '0;
  logic [31:0]   pc;
  logic          flush, redirect;
  logic [CW-1:0] br_count, taken_count;

  int checks = 0;
  int failures = 0;

  // reference model: ignore window length replaces the FSM
  logic [31:0] m_pc;
  int          m_ign, m_br, m_tk;
  logic        m_redir;

  branch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_beq(br_beq), .z(z),
    .br_pc4(br_pc4), .br_imm(br_imm), .jump(jump), .jump_index(jump_index),
    .pc(pc), .flush(flush), .redirect(redirect), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_flush();
`ifdef BRANCH_DELAY_SLOT_EN
    return m_ign == 1;
`else
    return m_ign != 0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ign = 0; m_br = 0; m_tk = 0; m_redir = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_br_count", {28'b0, br_count}, 32'h0);
    chk("rst_taken_count", {28'b0, taken_count}, 32'h0);
    stall = 1'b0; br_valid = 1'b0; jump = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic step(input logic s, input logic bv, input logic bq, input logic zz,
                      input logic [31:0] p4, input logic [15:0] im,
                      input logic j, input logic [25:0] ji);
    logic        tk, a;
    logic [31:0] tgt;
    @(negedge clk);
    stall = s; br_valid = bv; br_beq = bq; z = zz; br_pc4 = p4; br_imm = im;
    jump = j; jump_index = ji;
    #1;
    chk("pc", pc, m_pc);
    chk("flush", {31'b0, flush}, {31'b0, exp_flush()});
    chk("redirect", {31'b0, redirect}, {31'b0, m_redir & ~s});
    chk("br_count", {28'b0, br_count}, 32'(m_br % 16));
    chk("taken_count", {28'b0, taken_count}, 32'(m_tk % 16));
    tk  = bv & (bq ? zz : ~zz);
    a   = (m_ign == 0) && !s && (tk || j);
    tgt = j ? {p4[31:28], ji, 2'b00} : p4 + 32'(int'($signed(im)) * 4);
    if (!s) begin
      if (m_ign == 0 && bv) m_br++;
      if (m_ign == 0 && tk) m_tk++;
      m_pc  = a ? tgt : m_pc + 32'd4;
      m_ign = a ? 2 : (m_ign > 0 ? m_ign - 1 : 0);
    end
    m_redir = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic s);
    step(s, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 26'h0);
  endtask

  initial begin
    model_reset();
    do_reset();
    idle(0); idle(0); idle(0);
    chk("pc_after_3", pc, 32'd12);

    // BEQ taken, backwards offset of two words
    step(0, 1, 1, 1, 32'h100, 16'hFFFE, 0, 26'h0);
    chk("beq_pc", pc, 32'hF8);
    chk("beq_redirect", {31'b0, redirect}, 32'h1);
    idle(0); idle(0); idle(0);

    // BNE with z=1 is not taken
    step(0, 1, 0, 1, 32'h200, 16'h0010, 0, 26'h0);
    chk("bne_taken_count", {28'b0, taken_count}, 32'h1);
    idle(0);

    // jump, then a branch in the squash window is ignored
    step(0, 0, 0, 0, 32'h1000_0010, 16'h0, 1, 26'h0000040);
    chk("jump_pc", pc, 32'h1000_0100);
    step(0, 1, 1, 1, 32'h1000_0104, 16'h0008, 0, 26'h0);
    chk("squash_br_count", {28'b0, br_count}, 32'h2);
    idle(0); idle(0);

    // stalled taken branch redirects on the first free edge
    step(1, 1, 1, 1, 32'h300, 16'h0004, 0, 26'h0);
    step(1, 1, 1, 1, 32'h300, 16'h0004, 0, 26'h0);
    step(1, 1, 1, 1, 32'h300, 16'h0004, 0, 26'h0);
    step(0, 1, 1, 1, 32'h300, 16'h0004, 0, 26'h0);
    chk("stall_release_pc", pc, 32'h310);
    idle(0); idle(0); idle(0);

    // reset while squashing
    step(0, 0, 0, 0, 32'h2000_0000, 16'h0, 1, 26'h0000123);
    do_reset();
    idle(0);

    // 16 resolved branches wrap a 4-bit counter
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 32'h40, 16'h0, 0, 26'h0);
    chk("wrap_br_count", {28'b0, br_count}, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom, 16'($urandom), ($urandom_range(0, 7) == 0),
           26'($urandom));
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
